// File: rtl/afe_spi_master.sv
// ============================================================================
// Module   : afe_spi_master
// Brief    : SPI mode-0 initiator for the AFE configuration port. Accepts
//            one register read/write command at a time and serialises it as
//            a {R/W, address, data} frame, MSB first. Read data comes back
//            with a single-cycle rsp_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module afe_spi_master #(
  parameter int CLK_DIV    = 4,   // clk cycles per SCLK half-period, 1..255
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  spi_clk,
  output logic                  spi_sen,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int FRAME_LEN = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W     = $clog2(CLK_DIV + 1);
  localparam int BIT_W     = $clog2(FRAME_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_LEN - 1);
  // Index (in transmit order) of the first data bit; MISO is only
  // meaningful from this bit onwards.
  localparam logic [BIT_W-1:0] DATA_FIRST = BIT_W'(1 + ADDR_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t                  state_q,     state_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;
  logic [BIT_W-1:0]        bit_q,       bit_d;
  logic                    phase_hi_q,  phase_hi_d;
  logic [FRAME_LEN-1:0]    shift_q,     shift_d;
  logic [DATA_WIDTH-1:0]   rx_q,        rx_d;
  logic                    rw_q,        rw_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rdata_q,     rdata_d;

  logic                    cnt_last;
  logic [DATA_WIDTH-1:0]   wdata_eff;

  assign cnt_last  = (cnt_q == CNT_LAST);
  // Reads transmit zeros in the data field.
  assign wdata_eff = cmd_rw ? {DATA_WIDTH{1'b0}} : cmd_wdata;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      phase_hi_q  <= 1'b0;
      shift_q     <= '0;
      rx_q        <= '0;
      rw_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      phase_hi_q  <= phase_hi_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state logic: phase timing, bit sequencing, shifting and capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    phase_hi_d  = phase_hi_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    rw_d        = rw_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;

    case (state_q)
      ST_IDLE: begin
        // cmd_ready is high throughout IDLE, so cmd_valid alone accepts.
        if (cmd_valid) begin
          state_d    = ST_SETUP;
          cnt_d      = '0;
          bit_d      = '0;
          phase_hi_d = 1'b0;
          rw_d       = cmd_rw;
          shift_d    = {cmd_rw, cmd_addr, wdata_eff};
          rx_d       = '0;
        end
      end

      ST_SETUP: begin
        // Chip enable asserted and first bit on MOSI one half-period
        // before the first rising edge.
        if (cnt_last) begin
          state_d    = ST_SHIFT;
          cnt_d      = '0;
          phase_hi_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (!cnt_last) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (phase_hi_q) begin
            // Last cycle of the high phase: sample MISO, then SCLK falls
            // and the next bit is presented while the clock is low.
            phase_hi_d = 1'b0;
            shift_d    = {shift_q[FRAME_LEN-2:0], 1'b0};
            if (bit_q >= DATA_FIRST) begin
              rx_d = {rx_q[DATA_WIDTH-2:0], spi_miso};
            end
          end else if (bit_q == BIT_LAST) begin
            state_d = ST_HOLD;
          end else begin
            bit_d      = bit_q + 1'b1;
            phase_hi_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        // Chip enable held after the final falling edge; the response is
        // published as the enable deasserts.
        if (cnt_last) begin
          state_d     = ST_GAP;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rdata_d     = rw_q ? rx_q : {DATA_WIDTH{1'b0}};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        // Minimum deselect time before another command can start.
        if (cnt_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign spi_clk   = (state_q == ST_SHIFT) & phase_hi_q;
  assign spi_sen   = ~((state_q == ST_SETUP) | (state_q == ST_SHIFT) |
                       (state_q == ST_HOLD));
  assign spi_mosi  = ((state_q == ST_SETUP) | (state_q == ST_SHIFT)) &
                     shift_q[FRAME_LEN-1];
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_afe_spi_master.sv
// ============================================================================
// Module   : tb_afe_spi_master
// Brief    : Self-checking bench for afe_spi_master. Two instances run side
//            by side (half-period 4 and 1 clk) against a behavioural AFE
//            model and a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_afe_spi_master;

  localparam int FRAME_BITS = 16;

  logic       clk = 1'b0;
  logic [1:0] rst_n;
  logic [1:0] cmd_valid;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [1:0] miso;

  wire  [1:0] cmd_ready, busy, rsp_valid, sclk, sen, mosi;
  wire  [7:0] rdata0, rdata1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Monitor / AFE model state, written only by the monitor process.
  int         sen_cnt[2], rises[2], hi_cnt[2], last_rise_cyc[2], period[2];
  int         last_len[2], last_rises[2], last_gap[2];
  int         frames_done[2], rsp_cnt[2];
  logic [15:0] frame[2], last_frame[2];
  logic       mode_err[2], last_mode_err[2], end_rsp[2];
  logic [7:0] rsp_data[2];
  logic [1:0] prev_sclk, prev_sen, prev_mosi;
  // Byte the AFE model returns during the data bits (set by stimulus).
  logic [7:0] afe_resp[2];

  afe_spi_master #(.CLK_DIV(4), .ADDR_WIDTH(7), .DATA_WIDTH(8)) u_dut4 (
    .clk(clk), .reset_n(rst_n[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rdata0), .busy(busy[0]),
    .spi_clk(sclk[0]), .spi_sen(sen[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );

  afe_spi_master #(.CLK_DIV(1), .ADDR_WIDTH(7), .DATA_WIDTH(8)) u_dut1 (
    .clk(clk), .reset_n(rst_n[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rdata1), .busy(busy[1]),
    .spi_clk(sclk[1]), .spi_sen(sen[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );

  always #5 clk = ~clk;

  // Cycle counter used for acceptance timing.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rdata_of(input int k);
    return (k == 0) ? rdata0 : rdata1;
  endfunction

  function automatic int half_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Behavioural AFE + bus monitor: samples both buses on the falling clk
  // edge, records each frame seen while sen is low, and drives MISO on
  // SCLK falling edges (data byte during the last 8 bits, noise otherwise).
  initial begin
    miso      = 2'b00;
    prev_sclk = 2'b00;
    prev_sen  = 2'b11;
    prev_mosi = 2'b00;
    for (int k = 0; k < 2; k++) begin
      sen_cnt[k] = 0; rises[k] = 0; hi_cnt[k] = 0; last_rise_cyc[k] = 0;
      period[k] = 0; last_len[k] = 0; last_rises[k] = 0; last_gap[k] = 0;
      frames_done[k] = 0; rsp_cnt[k] = 0; frame[k] = '0; last_frame[k] = '0;
      mode_err[k] = 1'b0; last_mode_err[k] = 1'b0; end_rsp[k] = 1'b0;
      rsp_data[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rsp_valid[k] === 1'b1) begin
          rsp_cnt[k]++;
          rsp_data[k] = rdata_of(k);
        end
        if (sen[k] === 1'b0) begin
          if (prev_sen[k]) begin
            last_gap[k] = hi_cnt[k];
            sen_cnt[k]  = 0;
            rises[k]    = 0;
            frame[k]    = '0;
            mode_err[k] = 1'b0;
          end
          sen_cnt[k]++;
          if (sclk[k] && !prev_sclk[k]) begin
            rises[k]++;
            frame[k] = {frame[k][14:0], mosi[k]};
            if (rises[k] > 1) period[k] = cyc - last_rise_cyc[k];
            last_rise_cyc[k] = cyc;
          end
          if (sclk[k] && (mosi[k] != prev_mosi[k])) mode_err[k] = 1'b1;
          if (!sclk[k] && prev_sclk[k]) begin
            if (rises[k] >= 8 && rises[k] <= 15)
              miso[k] = afe_resp[k][3'(15 - rises[k])];
            else
              miso[k] = 1'($urandom);
          end
        end else begin
          if (!prev_sen[k]) begin
            last_len[k]      = sen_cnt[k];
            last_rises[k]    = rises[k];
            last_frame[k]    = frame[k];
            last_mode_err[k] = mode_err[k];
            end_rsp[k]       = rsp_valid[k];
            frames_done[k]++;
            hi_cnt[k]        = 0;
          end
          hi_cnt[k]++;
        end
      end
      prev_sclk = sclk;
      prev_sen  = sen;
      prev_mosi = mosi;
    end
  end

  // Must be called at a falling clk edge; returns just after the
  // accepting rising edge with cmd_valid still high.
  task automatic issue(input int k, input logic rw, input logic [6:0] a,
                       input logic [7:0] d, output int acc);
    cmd_rw       = rw;
    cmd_addr     = a;
    cmd_wdata    = d;
    cmd_valid[k] = 1'b1;
    acc          = -1;
    for (int i = 0; i < 3000; i++) begin
      if (cmd_ready[k]) begin
        acc = cyc;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) check_eq("accept_timeout", 0, 1);
  endtask

  task automatic wait_frame(input int k, input int n0);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (frames_done[k] > n0) break;
      @(negedge clk);
    end
    if (i == 3000) check_eq("frame_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // Frame-level reference: what the AFE must have seen and what must come back.
  task automatic check_frame(input int k, input logic rw, input logic [6:0] a,
                             input logic [7:0] d, input logic [7:0] resp, input int exp_rsp);
    logic [15:0] exp_frame;
    logic [7:0]  exp_rdata;
    int          h;
    h         = half_of(k);
    exp_frame = {rw, a, (rw ? 8'h00 : d)};
    exp_rdata = rw ? resp : 8'h00;
    check_eq("mosi_frame",      last_frame[k],    exp_frame);
    check_eq("sen_low_cycles",  last_len[k],      (2 * FRAME_BITS + 2) * h);
    check_eq("sclk_rises",      last_rises[k],    FRAME_BITS);
    check_eq("sclk_period",     period[k],        2 * h);
    check_eq("mode0_mosi",      last_mode_err[k], 0);
    check_eq("rsp_at_sen_rise", end_rsp[k],       1);
    check_eq("rsp_count",       rsp_cnt[k],       exp_rsp);
    check_eq("rsp_rdata",       rsp_data[k],      exp_rdata);
    check_eq("rdata_held",      rdata_of(k),      exp_rdata);
  endtask

  task automatic run_frame(input int k, input logic rw, input logic [6:0] a,
                           input logic [7:0] d, input logic [7:0] resp);
    int acc, n0, r0;
    afe_resp[k] = resp;
    n0 = frames_done[k];
    r0 = rsp_cnt[k];
    issue(k, rw, a, d, acc);
    @(negedge clk);
    cmd_valid[k] = 1'b0;
    wait_frame(k, n0);
    check_frame(k, rw, a, d, resp, r0 + 1);
  endtask

  initial begin
    int accA, accB, n0, r0, i;
    rst_n       = 2'b00;
    cmd_valid   = 2'b00;
    cmd_rw      = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    afe_resp[0] = 8'h00;
    afe_resp[1] = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state on both instances.
    for (int k = 0; k < 2; k++) begin
      check_eq("reset_ready", cmd_ready[k], 1);
      check_eq("reset_busy",  busy[k],      0);
      check_eq("reset_rsp",   rsp_valid[k], 0);
      check_eq("reset_sclk",  sclk[k],      0);
      check_eq("reset_sen",   sen[k],       1);
      check_eq("reset_mosi",  mosi[k],      0);
      check_eq("reset_rdata", rdata_of(k),  0);
    end
    rst_n = 2'b11;
    @(negedge clk);

    // Write 0x12 <- 0x05, then read 0x7F returning 0xA5.
    run_frame(0, 1'b0, 7'h12, 8'h05, 8'h5A);
    run_frame(0, 1'b1, 7'h7F, 8'h3E, 8'hA5);

    // Half-period of one clk: read returning 0x3C.
    run_frame(1, 1'b1, 7'h21, 8'hFF, 8'h3C);

    // Back-to-back commands with cmd_valid held high.
    n0 = frames_done[0];
    r0 = rsp_cnt[0];
    afe_resp[0] = 8'h96;
    issue(0, 1'b0, 7'h33, 8'hC7, accA);
    @(negedge clk);
    check_eq("busy_in_frame", busy[0], 1);
    issue(0, 1'b1, 7'h4C, 8'h11, accB);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    check_eq("b2b_spacing", accB - accA, (2 * FRAME_BITS + 3) * 4 + 1);
    wait_frame(0, n0 + 1);
    check_eq("sen_gap", last_gap[0], 4 + 1);
    check_frame(0, 1'b1, 7'h4C, 8'h11, 8'h96, r0 + 2);

    // Reset pulse near the 8th SCLK rise abandons the frame.
    n0 = frames_done[0];
    r0 = rsp_cnt[0];
    issue(0, 1'b0, 7'h55, 8'hAA, accA);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    for (i = 0; i < 500; i++) begin
      if (rises[0] >= 8) break;
      @(negedge clk);
    end
    if (i == 500) check_eq("rise8_timeout", 0, 1);
    rst_n[0] = 1'b0;
    @(negedge clk);
    check_eq("midrst_sen",   sen[0],       1);
    check_eq("midrst_sclk",  sclk[0],      0);
    check_eq("midrst_ready", cmd_ready[0], 1);
    check_eq("midrst_rdata", rdata0,       0);
    rst_n[0] = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("midrst_no_rsp", rsp_cnt[0], r0);
    run_frame(0, 1'b0, 7'h0A, 8'h5C, 8'h00);

    // Stray cmd_valid pulse with a different command mid-frame is ignored.
    n0 = frames_done[0];
    r0 = rsp_cnt[0];
    afe_resp[0] = 8'h69;
    issue(0, 1'b1, 7'h2B, 8'h00, accA);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    repeat (40) @(negedge clk);
    cmd_rw       = 1'b0;
    cmd_addr     = 7'h2B ^ 7'h55;
    cmd_wdata    = 8'hE1;
    cmd_valid[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    wait_frame(0, n0);
    check_frame(0, 1'b1, 7'h2B, 8'h00, 8'h69, r0 + 1);
    repeat (200) @(negedge clk);
    check_eq("no_extra_frame", frames_done[0], n0 + 1);

    // Randomised commands on both instances.
    for (int t = 0; t < 10; t++) begin
      int         k;
      logic       rw;
      logic [6:0] a;
      logic [7:0] d, resp;
      k    = int'($urandom_range(0, 1));
      rw   = 1'($urandom);
      a    = 7'($urandom);
      d    = 8'($urandom);
      resp = 8'($urandom);
      run_frame(k, rw, a, d, resp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
